// File: rtl/battleship_pkg.sv
`default_nettype none
// ============================================================================
// Module   : battleship_pkg
// Purpose  : Shared types and constants for the battleship shooter.
// Revision : 1.0 - initial release
// ============================================================================
package battleship_pkg;

    localparam int c_BOARD_DIM = 10;

    typedef logic [3:0] coord_t;

    typedef enum logic [1:0] {
        RES_HIT  = 2'd0,
        RES_NEAR = 2'd1,
        RES_MISS = 2'd2
    } result_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_FIRE   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_E = 2'd1,
        DIR_S = 2'd2,
        DIR_W = 2'd3
    } dir_t;

    // Row-major cell index, X fastest.
    function automatic int cell_idx(coord_t x, coord_t y, int dim);
        return int'(y) * dim + int'(x);
    endfunction

endpackage
`default_nettype wire

// File: rtl/battleship_shooter_shot_map.sv
`default_nettype none
// ============================================================================
// Module   : shot_map
// Purpose  : Bitmap of fired cells; synchronous set/clear, combinational query.
// Revision : 1.0 - initial release
// ============================================================================
module shot_map
    import battleship_pkg::*;
#(
    parameter int BOARD_DIM = c_BOARD_DIM
) (
    input  logic   clock,
    input  logic   reset_L,
    input  logic   i_clear,
    input  logic   i_set,
    input  coord_t i_set_x,
    input  coord_t i_set_y,
    input  coord_t i_qx,
    input  coord_t i_qy,
    output logic   o_fired
);

    localparam int c_CELLS = BOARD_DIM * BOARD_DIM;
    localparam int c_IW    = $clog2(c_CELLS);

    logic [c_CELLS-1:0] r_map;
    logic [c_IW-1:0]    w_set_idx;
    logic [c_IW-1:0]    w_q_idx;
    logic               w_set_on;
    logic               w_q_on;

    assign w_set_idx = c_IW'(cell_idx(i_set_x, i_set_y, BOARD_DIM));
    assign w_q_idx   = c_IW'(cell_idx(i_qx, i_qy, BOARD_DIM));
    assign w_set_on  = ({1'b0, i_set_x} < 5'(BOARD_DIM)) && ({1'b0, i_set_y} < 5'(BOARD_DIM));
    assign w_q_on    = ({1'b0, i_qx} < 5'(BOARD_DIM)) && ({1'b0, i_qy} < 5'(BOARD_DIM));

    // Off-board queries report "fired" so callers never select them.
    assign o_fired = w_q_on ? r_map[w_q_idx] : 1'b1;

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_map <= '0;
        end else if (i_clear) begin
            r_map <= '0;
        end else if (i_set && w_set_on) begin
            r_map[w_set_idx] <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/battleship_shooter.sv
`default_nettype none
// ============================================================================
// Module   : battleship_shooter
// Purpose  : Hunt/target automated shooter driving the scoring device.
//            Big-shot logic is built only when SHOOTER_BIG_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module battleship_shooter
    import battleship_pkg::*;
#(
    parameter int BOARD_DIM    = c_BOARD_DIM,
    parameter int HITS_TO_WIN  = 17,
    parameter int MAX_SHOTS    = 100,
    parameter int NUM_BIG      = 3,
    parameter int RESP_TIMEOUT = 8
) (
    input  logic       clock,
    input  logic       reset_L,
    input  logic       start,
    input  logic       Hit,
    input  logic       NearMiss,
    input  logic       Miss,
    input  logic       SomethingIsWrong,
    output logic [3:0] X,
    output logic [3:0] Y,
    output logic       Big,
    output logic [1:0] BigLeft,
    output logic       ScoreThis,
    output logic       busy,
    output logic       done,
    output logic       won,
    output logic       err,
    output logic [6:0] shot_count,
    output logic [4:0] hit_count
);

    state_t     r_state, w_state_n;
    coord_t     r_x, r_y, r_hx, r_hy, r_ax, r_ay;
    coord_t     w_hx_n, w_hy_n, w_nb_x, w_nb_y, w_cx, w_cy;
    logic       r_pass, r_hunt_done, r_tgt, r_won;
    logic       w_pass_n, w_hdone_n, w_nb_on, w_fired, w_cand_ok;
    dir_t       r_dir;
    logic [6:0] r_shots;
    logic [4:0] r_hits;
    logic [7:0] r_wait_cnt;
    logic [4:0] w_x2, w_y1, w_ax1, w_ay1;
    logic [1:0] w_nresp;
    logic       w_launch, w_bad, w_accept, w_timeout, w_is_hit, w_win, w_out_of_shots;
    result_t    w_res;

    assign w_launch = start && (r_state == ST_IDLE || r_state == ST_DONE || r_state == ST_ERROR);

    assign w_nresp        = 2'(Hit) + 2'(NearMiss) + 2'(Miss);
    assign w_bad          = SomethingIsWrong || (w_nresp > 2'd1);
    assign w_accept       = !SomethingIsWrong && (w_nresp == 2'd1);
    assign w_timeout      = (w_nresp == 2'd0) && (r_wait_cnt == 8'(RESP_TIMEOUT - 1));
    assign w_res          = Hit ? RES_HIT : (NearMiss ? RES_NEAR : RES_MISS);
    assign w_is_hit       = w_accept && (w_res == RES_HIT);
    assign w_win          = w_is_hit && ((r_hits + 5'd1) == 5'(HITS_TO_WIN));
    assign w_out_of_shots = (r_shots == 7'(MAX_SHOTS));

    // Neighbour of the anchor in the current probe direction.
    assign w_ax1 = {1'b0, r_ax} + 5'd1;
    assign w_ay1 = {1'b0, r_ay} + 5'd1;
    always_comb begin
        w_nb_x  = r_ax;
        w_nb_y  = r_ay;
        w_nb_on = 1'b0;
        case (r_dir)
            DIR_N:   begin w_nb_y = r_ay - 4'd1; w_nb_on = (r_ay != 4'd0); end
            DIR_E:   begin w_nb_x = w_ax1[3:0];  w_nb_on = (w_ax1 < 5'(BOARD_DIM)); end
            DIR_S:   begin w_nb_y = w_ay1[3:0];  w_nb_on = (w_ay1 < 5'(BOARD_DIM)); end
            default: begin w_nb_x = r_ax - 4'd1; w_nb_on = (r_ax != 4'd0); end
        endcase
    end

    // Hunt cursor steps by two within a row, keeping (X+Y) parity equal to the pass.
    assign w_x2 = {1'b0, r_hx} + 5'd2;
    assign w_y1 = {1'b0, r_hy} + 5'd1;
    always_comb begin
        w_hx_n    = w_x2[3:0];
        w_hy_n    = r_hy;
        w_pass_n  = r_pass;
        w_hdone_n = 1'b0;
        if (w_x2 >= 5'(BOARD_DIM)) begin
            if (w_y1 < 5'(BOARD_DIM)) begin
                w_hy_n = w_y1[3:0];
                w_hx_n = {3'b000, w_y1[0] ^ r_pass};
            end else if (!r_pass) begin
                w_pass_n = 1'b1;
                w_hy_n   = 4'd0;
                w_hx_n   = 4'd1;
            end else begin
                w_hdone_n = 1'b1;
                w_hx_n    = r_hx;
            end
        end
    end

    assign w_cx      = r_tgt ? w_nb_x : r_hx;
    assign w_cy      = r_tgt ? w_nb_y : r_hy;
    assign w_cand_ok = r_tgt ? (w_nb_on && !w_fired) : (!r_hunt_done && !w_fired);

    shot_map #(.BOARD_DIM(BOARD_DIM)) u_shot_map (
        .clock   (clock),
        .reset_L (reset_L),
        .i_clear (w_launch),
        .i_set   (r_state == ST_FIRE),
        .i_set_x (r_x),
        .i_set_y (r_y),
        .i_qx    (w_cx),
        .i_qy    (w_cy),
        .o_fired (w_fired)
    );

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) r_state <= ST_IDLE;
        else          r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: if (start) w_state_n = ST_SELECT;
            ST_SELECT: begin
                if (!r_tgt && r_hunt_done) w_state_n = ST_DONE;
                else if (w_cand_ok)        w_state_n = ST_FIRE;
            end
            ST_FIRE: w_state_n = ST_WAIT;
            ST_WAIT: begin
                if (w_bad)          w_state_n = ST_ERROR;
                else if (w_accept)  w_state_n = (w_win || w_out_of_shots) ? ST_DONE : ST_SELECT;
                else if (w_timeout) w_state_n = ST_ERROR;
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_x <= '0; r_y <= '0; r_hx <= '0; r_hy <= '0; r_ax <= '0; r_ay <= '0;
            r_pass <= 1'b0; r_hunt_done <= 1'b0; r_tgt <= 1'b0; r_won <= 1'b0;
            r_dir <= DIR_N; r_shots <= '0; r_hits <= '0; r_wait_cnt <= '0;
        end else begin
            if (w_launch) begin
                r_hx <= '0; r_hy <= '0; r_pass <= 1'b0; r_hunt_done <= 1'b0;
                r_tgt <= 1'b0; r_dir <= DIR_N; r_shots <= '0; r_hits <= '0; r_won <= 1'b0;
            end
            case (r_state)
                ST_SELECT: begin
                    if (w_cand_ok) begin
                        r_x <= w_cx;
                        r_y <= w_cy;
                    end
                    if (r_tgt) begin
                        if (r_dir == DIR_W) r_tgt <= 1'b0;
                        else                r_dir <= dir_t'(r_dir + 2'd1);
                    end else if (!r_hunt_done) begin
                        r_hx        <= w_hx_n;
                        r_hy        <= w_hy_n;
                        r_pass      <= w_pass_n;
                        r_hunt_done <= w_hdone_n;
                    end
                end
                ST_FIRE: begin
                    r_shots    <= r_shots + 7'd1;
                    r_wait_cnt <= '0;
                end
                ST_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 8'd1;
                    if (w_is_hit) begin
                        r_hits <= r_hits + 5'd1;
                        r_tgt  <= 1'b1;
                        r_ax   <= r_x;
                        r_ay   <= r_y;
                        r_dir  <= DIR_N;
                        if (w_win) r_won <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SHOOTER_BIG_EN
    logic [1:0] r_budget, r_bigleft;
    logic       r_near, r_big;

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_budget <= '0; r_bigleft <= '0; r_near <= 1'b0; r_big <= 1'b0;
        end else begin
            if (w_launch) begin
                r_budget <= 2'(NUM_BIG);
                r_near   <= 1'b0;
                r_big    <= 1'b0;
            end
            if (r_state == ST_SELECT && w_cand_ok) begin
                r_big     <= r_near && (r_budget != 2'd0);
                r_bigleft <= r_budget;
                r_near    <= 1'b0;
            end
            if (r_state == ST_FIRE && r_big) r_budget <= r_budget - 2'd1;
            if (r_state == ST_WAIT && w_accept && w_res == RES_NEAR) r_near <= 1'b1;
        end
    end

    assign Big     = r_big;
    assign BigLeft = r_bigleft;
`else
    assign Big     = 1'b0;
    assign BigLeft = 2'(NUM_BIG) & 2'b00;
`endif

    assign X          = r_x;
    assign Y          = r_y;
    assign ScoreThis  = (r_state == ST_FIRE);
    assign busy       = (r_state == ST_SELECT) || (r_state == ST_FIRE) || (r_state == ST_WAIT);
    assign done       = (r_state == ST_DONE) || (r_state == ST_ERROR);
    assign err        = (r_state == ST_ERROR);
    assign won        = r_won;
    assign shot_count = r_shots;
    assign hit_count  = r_hits;

endmodule
`default_nettype wire

// File: tb/tb_battleship_shooter.sv
`default_nettype none
// ============================================================================
// Module   : tb_battleship_shooter
// Purpose  : Randomized self-checking bench with a hunt/target reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_battleship_shooter;

    localparam int c_DIM = 10, c_WIN = 17, c_MAXS = 100, c_NBIG = 3, c_TMO = 8;
    localparam int c_R_HIT = 0, c_R_NEAR = 1, c_R_MISS = 2, c_R_BOTH = 3;
    localparam int c_P_MISS = 0, c_P_HIT44 = 1, c_P_HIT00 = 2, c_P_NEAR = 3, c_P_RAND = 4;

    logic       clock = 1'b0, reset_L = 1'b0, start = 1'b0;
    logic       Hit = 1'b0, NearMiss = 1'b0, Miss = 1'b0, SomethingIsWrong = 1'b0;
    logic [3:0] X, Y;
    logic       Big, ScoreThis, busy, done, won, err;
    logic [1:0] BigLeft;
    logic [6:0] shot_count;
    logic [4:0] hit_count;

    battleship_shooter dut (
        .clock(clock), .reset_L(reset_L), .start(start),
        .Hit(Hit), .NearMiss(NearMiss), .Miss(Miss), .SomethingIsWrong(SomethingIsWrong),
        .X(X), .Y(Y), .Big(Big), .BigLeft(BigLeft), .ScoreThis(ScoreThis),
        .busy(busy), .done(done), .won(won), .err(err),
        .shot_count(shot_count), .hit_count(hit_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: ordered hunt list plus a four-direction probe around the last hit.
    bit         m_fired[c_DIM][c_DIM];
    int         m_hq[$];
    bit         m_tgt, m_near;
    int         m_ax, m_ay, m_dir, m_shots, m_hits, m_budget;
    logic [7:0] obs[$];

    task automatic model_reset();
        for (int x = 0; x < c_DIM; x++)
            for (int y = 0; y < c_DIM; y++) m_fired[x][y] = 1'b0;
        m_hq.delete();
        for (int p = 0; p < 2; p++)
            for (int y = 0; y < c_DIM; y++)
                for (int x = 0; x < c_DIM; x++)
                    if ((x + y) % 2 == p) m_hq.push_back(y * c_DIM + x);
        m_tgt = 0; m_near = 0; m_dir = 0; m_shots = 0; m_hits = 0; m_budget = c_NBIG;
    endtask

    task automatic model_next(output int ex, output int ey, output bit none);
        int nx, ny, c;
        none = 0; ex = 0; ey = 0;
        while (m_tgt && m_dir < 4) begin
            nx = m_ax; ny = m_ay;
            case (m_dir)
                0: ny--;
                1: nx++;
                2: ny++;
                default: nx--;
            endcase
            m_dir++;
            if (nx >= 0 && nx < c_DIM && ny >= 0 && ny < c_DIM && !m_fired[nx][ny]) begin
                ex = nx; ey = ny;
                if (m_dir == 4) m_tgt = 0;
                return;
            end
        end
        m_tgt = 0;
        while (m_hq.size() > 0) begin
            c = m_hq.pop_front();
            if (!m_fired[c % c_DIM][c / c_DIM]) begin
                ex = c % c_DIM; ey = c / c_DIM;
                return;
            end
        end
        none = 1;
    endtask

    function automatic int pick(input int policy, input int x, input int y);
        int r;
        case (policy)
            c_P_HIT44: return (x == 4 && y == 4) ? c_R_HIT : c_R_MISS;
            c_P_HIT00: return (x == 0 && y == 0) ? c_R_HIT : c_R_MISS;
            c_P_NEAR:  return c_R_NEAR;
            c_P_RAND: begin
                r = int'($urandom_range(0, 99));
                return (r < 35) ? c_R_HIT : ((r < 50) ? c_R_NEAR : c_R_MISS);
            end
            default:   return c_R_MISS;
        endcase
    endfunction

    task automatic drive_resp(input int kind);
        Hit      = (kind == c_R_HIT) || (kind == c_R_BOTH);
        NearMiss = (kind == c_R_NEAR);
        Miss     = (kind == c_R_MISS) || (kind == c_R_BOTH);
    endtask

    task automatic do_reset();
        reset_L = 1'b0; start = 1'b0; SomethingIsWrong = 1'b0;
        drive_resp(-1);
        repeat (2) @(negedge clock);
        reset_L = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
    endtask

    task automatic wait_fire(output bit fired);
        fired = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (ScoreThis) begin fired = 1; break; end
            if (done) break;
        end
    endtask

    task automatic play(input int policy, input int limit, input bit rand_delay);
        int ex, ey, kind, d, eb, ebl;
        bit none, f;
        pulse_start();
        check("busy_after_start", busy, 1);
        check("shots_cleared", shot_count, 0);
        check("err_cleared", err, 0);
        check("done_cleared", done, 0);
        model_reset();
        obs.delete();
        for (int s = 0; s < limit; s++) begin
            model_next(ex, ey, none);
            if (none) begin
                for (int i = 0; i < 300 && !done; i++) @(negedge clock);
                check("exhaust_done", done, 1);
                check("exhaust_won", won, 0);
                return;
            end
            wait_fire(f);
            check("fire_seen", f, 1);
            if (!f) return;
            obs.push_back({X, Y});
            check("shot_x", X, ex);
            check("shot_y", Y, ey);
`ifdef SHOOTER_BIG_EN
            eb = (m_near && m_budget > 0) ? 1 : 0;
            ebl = m_budget;
            m_near = 0;
            if (eb == 1) m_budget--;
`else
            eb = 0; ebl = 0;
`endif
            check("big", Big, eb);
            check("big_left", BigLeft, ebl);
            check("shot_count_fire", shot_count, m_shots);
            m_fired[ex][ey] = 1'b1;
            m_shots++;
            kind = pick(policy, ex, ey);
            d = rand_delay ? int'($urandom_range(1, c_TMO)) : 1;
            repeat (d) @(negedge clock);
            check("x_stable", X, ex);
            check("y_stable", Y, ey);
            drive_resp(kind);
            @(negedge clock);
            drive_resp(-1);
            if (kind == c_R_HIT) begin
                m_hits++; m_tgt = 1; m_ax = ex; m_ay = ey; m_dir = 0;
            end
            if (kind == c_R_NEAR) m_near = 1;
            check("hit_count", hit_count, m_hits);
            check("shot_count", shot_count, m_shots);
            if (m_hits == c_WIN || m_shots == c_MAXS) begin
                check("done_end", done, 1);
                check("won_end", won, (m_hits == c_WIN) ? 1 : 0);
                check("busy_end", busy, 0);
                return;
            end
            check("busy_mid", busy, 1);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit f;
        do_reset();
        @(negedge clock);
        check("rst_x", X, 0);            check("rst_y", Y, 0);
        check("rst_big", Big, 0);        check("rst_bigleft", BigLeft, 0);
        check("rst_scorethis", ScoreThis, 0);
        check("rst_busy", busy, 0);      check("rst_done", done, 0);
        check("rst_won", won, 0);        check("rst_err", err, 0);
        check("rst_shots", shot_count, 0); check("rst_hits", hit_count, 0);

        play(c_P_MISS, 200, 0);
        check("miss_first", obs[0], 'h00);
        check("miss_second", obs[1], 'h20);
        check("miss_third", obs[2], 'h40);
        check("miss_total", shot_count, 100);

        play(c_P_HIT44, 28, 0);
        check("hit44_anchor", obs[22], 'h44);
        check("hit44_n", obs[23], 'h43);
        check("hit44_e", obs[24], 'h54);
        check("hit44_s", obs[25], 'h45);
        check("hit44_w", obs[26], 'h34);
        check("hit44_resume", obs[27], 'h64);
        #2 reset_L = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_scorethis", ScoreThis, 0);
        check("midrst_shots", shot_count, 0);
        @(negedge clock) reset_L = 1'b1;

        play(c_P_HIT00, 3, 0);
        check("hit00_e", obs[1], 'h10);
        check("hit00_s", obs[2], 'h01);
        do_reset();

        play(c_P_NEAR, 5, 0);
        do_reset();

        // Response during FIRE must be ignored; then silence must time out.
        pulse_start();
        wait_fire(f);
        check("tmo_fire", f, 1);
        Hit = 1'b1;
        for (int k = 1; k <= c_TMO; k++) begin
            @(negedge clock);
            Hit = 1'b0;
            if (k == c_TMO) check("tmo_not_yet", err, 0);
        end
        @(negedge clock);
        check("tmo_err", err, 1);
        check("tmo_done", done, 1);
        check("tmo_busy", busy, 0);
        check("tmo_hits", hit_count, 0);

        pulse_start();
        check("restart_err", err, 0);
        wait_fire(f);
        check("both_fire", f, 1);
        check("both_x", X, 0);
        @(negedge clock);
        drive_resp(c_R_BOTH);
        @(negedge clock);
        drive_resp(-1);
        check("both_err", err, 1);
        check("both_done", done, 1);
        pulse_start();
        check("both_restart_err", err, 0);
        wait_fire(f);
        check("both_restart_xy", {X, Y}, 'h00);
        do_reset();

        for (int g = 0; g < 3; g++) begin
            play(c_P_RAND, 200, 1);
            do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
